// File: rtl/multicycle_maindec_pkg.sv
// Shared control definitions for the multicycle LEGv8 main decoder: states,
// opcode constants, opcode classes and the ALU operand/operation encodings.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC_R,
        S_RWB,
        S_BRANCH,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        OC_LDUR,
        OC_STUR,
        OC_CBZ,
        OC_RTYPE,
        OC_ILLEGAL
    } opclass_t;

    localparam logic [10:0] OP_LDUR    = 11'b11111000010;
    localparam logic [10:0] OP_STUR    = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ_PFX = 8'b10110100;
    localparam logic [10:0] OP_ADD     = 11'b10001011000;
    localparam logic [10:0] OP_SUB     = 11'b11001011000;
    localparam logic [10:0] OP_AND     = 11'b10001010000;
    localparam logic [10:0] OP_ORR     = 11'b10101010000;

    // Must stay in step with the ALU control decoder's aluop interpretation.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

endpackage

// File: rtl/multicycle_maindec_if.sv
// Control bundle between the main decoder (master) and the datapath (slave).
// The halt signal exists only when ILLEGAL_TRAP_EN is defined.
interface multicycle_maindec_if #(
    parameter int CNT_W = 32
);
    logic [10:0]      op;
    logic             zero;
    logic             mem_ready;
    logic [1:0]       aluop;
    logic             alusrc_a;
    logic [1:0]       alusrc_b;
    logic             reg2loc;
    logic             irwrite;
    logic             pcwrite;
    logic             pcsrc;
    logic             memread;
    logic             memwrite;
    logic             regwrite;
    logic             memtoreg;
    logic [CNT_W-1:0] instret;
`ifdef ILLEGAL_TRAP_EN
    logic             halt;

    modport master (
        input  op, zero, mem_ready,
        output aluop, alusrc_a, alusrc_b, reg2loc, irwrite, pcwrite, pcsrc,
               memread, memwrite, regwrite, memtoreg, instret, halt
    );
    modport slave (
        output op, zero, mem_ready,
        input  aluop, alusrc_a, alusrc_b, reg2loc, irwrite, pcwrite, pcsrc,
               memread, memwrite, regwrite, memtoreg, instret, halt
    );
`else
    modport master (
        input  op, zero, mem_ready,
        output aluop, alusrc_a, alusrc_b, reg2loc, irwrite, pcwrite, pcsrc,
               memread, memwrite, regwrite, memtoreg, instret
    );
    modport slave (
        output op, zero, mem_ready,
        input  aluop, alusrc_a, alusrc_b, reg2loc, irwrite, pcwrite, pcsrc,
               memread, memwrite, regwrite, memtoreg, instret
    );
`endif
endinterface

// File: rtl/multicycle_maindec_opclass_dec.sv
// Opcode classifier: op[10:0] -> {LDUR, STUR, CBZ, RTYPE, ILLEGAL}.
// Purely combinational, no latency, no backpressure.
module opclass_dec
    import ctrl_pkg::*;
(
    input  logic [10:0] op,
    output opclass_t    opclass
);

    always_comb begin
        opclass = OC_ILLEGAL;
        if (op == OP_LDUR) begin
            opclass = OC_LDUR;
        end else if (op == OP_STUR) begin
            opclass = OC_STUR;
        end else if (op[10:3] == OP_CBZ_PFX) begin
            opclass = OC_CBZ;
        end else if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR) begin
            opclass = OC_RTYPE;
        end
    end

endmodule

// File: rtl/multicycle_maindec.sv
// Multicycle LEGv8 main control FSM; ILLEGAL_TRAP_EN adds a sticky HALT state.
// Latency (mem_ready=1): LDUR 5, STUR 4, RTYPE 4, CBZ 3 cycles.
// Backpressure: FETCH, MEMRD and MEMWR stall until mem_ready.
module multicycle_maindec
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 32
)(
    input  logic                 clk,
    input  logic                 reset,
    multicycle_maindec_if.master bus
);

    state_t           state_q, state_d;
    opclass_t         opclass;
    logic [CNT_W-1:0] instret_q;
    logic             retire;

    logic [1:0] aluop, alusrc_b;
    logic       alusrc_a, reg2loc, irwrite, pcwrite, pcsrc;
    logic       memread, memwrite, regwrite, memtoreg, halt;

    opclass_dec u_opclass_dec (
        .op      (bus.op),
        .opclass (opclass)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                instret_q <= instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        retire   = 1'b0;
        aluop    = ALUOP_ADD;
        alusrc_a = 1'b0;
        alusrc_b = SRCB_REG;
        reg2loc  = 1'b0;
        irwrite  = 1'b0;
        pcwrite  = 1'b0;
        pcsrc    = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        regwrite = 1'b0;
        memtoreg = 1'b0;
        halt     = 1'b0;

        case (state_q)
            S_FETCH: begin
                memread  = 1'b1;
                alusrc_b = SRCB_FOUR;
                if (bus.mem_ready) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                reg2loc = (opclass == OC_STUR) || (opclass == OC_CBZ);
                case (opclass)
                    OC_LDUR, OC_STUR: state_d = S_MEMADR;
                    OC_RTYPE:         state_d = S_EXEC_R;
                    OC_CBZ:           state_d = S_BRANCH;
`ifdef ILLEGAL_TRAP_EN
                    default:          state_d = S_HALT;
`else
                    default:          state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                alusrc_a = 1'b1;
                alusrc_b = SRCB_IMM;
                reg2loc  = (opclass == OC_STUR);
                state_d  = (opclass == OC_STUR) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                memread = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                memwrite = 1'b1;
                reg2loc  = 1'b1;
                if (bus.mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC_R: begin
                alusrc_a = 1'b1;
                aluop    = ALUOP_RTYPE;
                state_d  = S_RWB;
            end
            S_RWB: begin
                regwrite = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                alusrc_a = 1'b1;
                aluop    = ALUOP_PASSB;
                reg2loc  = 1'b1;
                pcsrc    = 1'b1;
                pcwrite  = bus.zero;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            S_HALT: begin
                halt    = 1'b1;
                state_d = S_HALT;
            end
`endif
            default: state_d = S_FETCH;
        endcase

        // Strobes are forced quiet for the whole reset cycle, whatever the state.
        if (reset) begin
            aluop    = 2'b00;
            alusrc_a = 1'b0;
            alusrc_b = 2'b00;
            reg2loc  = 1'b0;
            irwrite  = 1'b0;
            pcwrite  = 1'b0;
            pcsrc    = 1'b0;
            memread  = 1'b0;
            memwrite = 1'b0;
            regwrite = 1'b0;
            memtoreg = 1'b0;
            halt     = 1'b0;
        end
    end

    assign bus.aluop    = aluop;
    assign bus.alusrc_a = alusrc_a;
    assign bus.alusrc_b = alusrc_b;
    assign bus.reg2loc  = reg2loc;
    assign bus.irwrite  = irwrite;
    assign bus.pcwrite  = pcwrite;
    assign bus.pcsrc    = pcsrc;
    assign bus.memread  = memread;
    assign bus.memwrite = memwrite;
    assign bus.regwrite = regwrite;
    assign bus.memtoreg = memtoreg;
    assign bus.instret  = instret_q;
`ifdef ILLEGAL_TRAP_EN
    assign bus.halt     = halt;
`endif

endmodule
